// File: rtl/riscv_pkg.sv
// Shared constants and pipeline-register records for the RISC-V pipelined core.
// The IF/ID record layout is the template that the later pipeline registers follow.
package riscv_pkg;

    localparam int          XLEN      = 64;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [63:0] RESET_PC  = 64'h0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instruction;
        logic            valid;
    } if_id_t;

    // What the fetch stage does on the coming edge, in priority order.
    typedef enum logic [1:0] {
        ACT_REDIRECT = 2'd0,
        ACT_STALL    = 2'd1,
        ACT_FETCH    = 2'd2,
        ACT_WAIT     = 2'd3
    } fetch_action_t;

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and instruction memory (slave).
interface instruction_fetch_stage_if;
    import riscv_pkg::*;

    logic [XLEN-1:0] imem_addr;
    logic            imem_req;
    logic [31:0]     imem_rdata;
    logic            imem_valid;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_rdata,
        output imem_valid
    );

endinterface

// File: rtl/instruction_fetch_stage_pc_select.sv
// Combinational next-PC selection: redirect beats stall beats fetch beats wait.
module pc_select
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            stall,
    input  logic            imem_valid,
    output logic [XLEN-1:0] next_pc,
    output fetch_action_t   action,
    output logic            misaligned
);

    logic [XLEN-1:0] aligned_target;
    logic [XLEN-1:0] seq_pc;

    assign aligned_target = {branch_target[XLEN-1:2], 2'b00};
    // Natural XLEN-bit overflow gives the required wrap from the top word to 0.
    assign seq_pc         = pc + XLEN'(4);

    always_comb begin
        next_pc    = pc;
        action     = ACT_WAIT;
        misaligned = 1'b0;
        if (branch_taken) begin
            next_pc    = aligned_target;
            action     = ACT_REDIRECT;
            misaligned = |branch_target[1:0];
        end else if (stall) begin
            action = ACT_STALL;
        end else if (imem_valid) begin
            next_pc = seq_pc;
            action  = ACT_FETCH;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage of the pipelined core: owns the PC, drives instruction memory and
// holds the IF/ID pipeline register consumed by decode and the immediate generator.
module instruction_fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = riscv_pkg::RESET_PC,
    parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       branch_taken,
    input  logic [XLEN-1:0]            branch_target,
    instruction_fetch_stage_if.master  imem,
    output logic [XLEN-1:0]            if_id_pc,
    output logic [31:0]                if_id_instruction,
    output logic                       if_id_valid,
    output logic                       fetch_misaligned
);

    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] pc_next;
    if_id_t          if_id_reg;
    logic            misaligned_reg;
    logic            misaligned_next;
    fetch_action_t   action;

    // A flushed or empty slot always carries the NOP so decode never sees stale bits.
    localparam if_id_t BUBBLE = '{pc: '0, instruction: NOP_INSTR, valid: 1'b0};

    pc_select u_pc_select (
        .pc            (pc_reg),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .stall         (stall),
        .imem_valid    (imem.imem_valid),
        .next_pc       (pc_next),
        .action        (action),
        .misaligned    (misaligned_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg         <= RESET_PC;
            if_id_reg      <= BUBBLE;
            misaligned_reg <= 1'b0;
        end else begin
            pc_reg         <= pc_next;
            misaligned_reg <= misaligned_next;
            case (action)
                ACT_REDIRECT: if_id_reg <= BUBBLE;
                ACT_STALL:    if_id_reg <= if_id_reg;
                ACT_FETCH:    if_id_reg <= '{pc: pc_reg, instruction: imem.imem_rdata, valid: 1'b1};
                default:      if_id_reg <= BUBBLE;
            endcase
        end
    end

    assign imem.imem_addr    = pc_reg;
    assign imem.imem_req     = !reset && !stall;
    assign if_id_pc          = if_id_reg.pc;
    assign if_id_instruction = if_id_reg.instruction;
    assign if_id_valid       = if_id_reg.valid;
    assign fetch_misaligned  = misaligned_reg;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed self-checking bench for instruction_fetch_stage: one task per scenario.
module tb_instruction_fetch_stage;
    import riscv_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            stall;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] if_id_pc;
    logic [31:0]     if_id_instruction;
    logic            if_id_valid;
    logic            fetch_misaligned;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    instruction_fetch_stage_if bus ();

    instruction_fetch_stage dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .imem              (bus.master),
        .if_id_pc          (if_id_pc),
        .if_id_instruction (if_id_instruction),
        .if_id_valid       (if_id_valid),
        .fetch_misaligned  (fetch_misaligned)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
        $display("cycle %0d: pc=%h if_id_pc=%h instr=%h valid=%b mis=%b req=%b",
                 cycle, bus.imem_addr, if_id_pc, if_id_instruction, if_id_valid,
                 fetch_misaligned, bus.imem_req);
    endtask

    task automatic drive(input logic rst, input logic stl, input logic br,
                         input logic [XLEN-1:0] tgt, input logic vld, input logic [31:0] rd);
        reset          = rst;
        stall          = stl;
        branch_taken   = br;
        branch_target  = tgt;
        bus.imem_valid = vld;
        bus.imem_rdata = rd;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 32'hDEAD_BEEF);
        step();
        checks++; if (bus.imem_addr !== 64'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", bus.imem_addr, 64'h0); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
        checks++; if (if_id_instruction !== 32'h13) begin errors++; $display("FAIL reset_instr: got %h want 00000013", if_id_instruction); end
        checks++; if (if_id_pc !== 64'h0) begin errors++; $display("FAIL reset_if_id_pc: got %h want 0", if_id_pc); end
        checks++; if (fetch_misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b want 0", fetch_misaligned); end
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
    endtask

    task automatic test_sequential_fetch();
        logic [XLEN-1:0] exp_pc [3] = '{64'h0, 64'h4, 64'h8};
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h00A0_0093);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (if_id_pc !== exp_pc[i]) begin errors++; $display("FAIL seq_if_id_pc[%0d]: got %h want %h", i, if_id_pc, exp_pc[i]); end
            checks++; if (if_id_instruction !== 32'h00A0_0093 || if_id_valid !== 1'b1) begin
                errors++; $display("FAIL seq_instr[%0d]: got %h/%b want 00a00093/1", i, if_id_instruction, if_id_valid);
            end
        end
        checks++; if (bus.imem_addr !== 64'hC) begin errors++; $display("FAIL seq_pc: got %h want c", bus.imem_addr); end
    endtask

    task automatic test_stall();
        drive(1'b0, 1'b1, 1'b0, '0, 1'b1, 32'h0020_0113);
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_req: got %b want 0", bus.imem_req); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (bus.imem_addr !== 64'hC || if_id_pc !== 64'h8 || if_id_valid !== 1'b1 || if_id_instruction !== 32'h00A0_0093) begin
                errors++; $display("FAIL stall_hold[%0d]: got pc=%h if_id_pc=%h valid=%b instr=%h want c/8/1/00a00093",
                                   i, bus.imem_addr, if_id_pc, if_id_valid, if_id_instruction);
            end
        end
        stall = 1'b0;
        #1;
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL release_req: got %b want 1", bus.imem_req); end
        step();
        checks++; if (if_id_pc !== 64'hC || if_id_instruction !== 32'h0020_0113 || bus.imem_addr !== 64'h10) begin
            errors++; $display("FAIL stall_resume: got if_id_pc=%h instr=%h pc=%h want c/00200113/10", if_id_pc, if_id_instruction, bus.imem_addr);
        end
    endtask

    task automatic test_redirect_with_stall();
        drive(1'b0, 1'b1, 1'b1, 64'h100, 1'b1, 32'h0030_0193);
        step();
        checks++; if (bus.imem_addr !== 64'h100) begin errors++; $display("FAIL redirect_pc: got %h want 100", bus.imem_addr); end
        checks++; if (if_id_valid !== 1'b0 || if_id_instruction !== 32'h13 || if_id_pc !== 64'h0) begin
            errors++; $display("FAIL redirect_flush: got valid=%b instr=%h pc=%h want 0/00000013/0", if_id_valid, if_id_instruction, if_id_pc);
        end
        checks++; if (fetch_misaligned !== 1'b0) begin errors++; $display("FAIL redirect_mis: got %b want 0", fetch_misaligned); end
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h0000_0513);
        step();
        checks++; if (if_id_pc !== 64'h100 || if_id_instruction !== 32'h0000_0513 || if_id_valid !== 1'b1) begin
            errors++; $display("FAIL redirect_target: got pc=%h instr=%h valid=%b want 100/00000513/1", if_id_pc, if_id_instruction, if_id_valid);
        end
    endtask

    task automatic test_misaligned();
        drive(1'b0, 1'b0, 1'b1, 64'h102, 1'b1, 32'h0000_0513);
        step();
        checks++; if (bus.imem_addr !== 64'h100) begin errors++; $display("FAIL mis_pc: got %h want 100", bus.imem_addr); end
        checks++; if (fetch_misaligned !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b want 1", fetch_misaligned); end
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h0000_0593);
        step();
        checks++; if (fetch_misaligned !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b want 0", fetch_misaligned); end
        checks++; if (if_id_pc !== 64'h100 || bus.imem_addr !== 64'h104) begin
            errors++; $display("FAIL mis_fetch: got if_id_pc=%h pc=%h want 100/104", if_id_pc, bus.imem_addr);
        end
    endtask

    task automatic test_imem_wait();
        drive(1'b0, 1'b0, 1'b1, 64'h20, 1'b1, 32'h0);
        step();
        bus.imem_valid = 1'b0;
        branch_taken   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (if_id_valid !== 1'b0 || if_id_instruction !== 32'h13 || bus.imem_addr !== 64'h20) begin
                errors++; $display("FAIL wait_bubble[%0d]: got valid=%b instr=%h pc=%h want 0/00000013/20", i, if_id_valid, if_id_instruction, bus.imem_addr);
            end
        end
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h0070_0393);
        step();
        checks++; if (if_id_pc !== 64'h20 || if_id_valid !== 1'b1 || if_id_instruction !== 32'h0070_0393) begin
            errors++; $display("FAIL wait_resume: got pc=%h valid=%b instr=%h want 20/1/00700393", if_id_pc, if_id_valid, if_id_instruction);
        end
    endtask

    task automatic test_wrap_and_reset();
        drive(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 32'h0);
        step();
        checks++; if (bus.imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_target: got %h want fffffffffffffffc", bus.imem_addr); end
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h0080_0413);
        step();
        checks++; if (bus.imem_addr !== 64'h0 || if_id_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            errors++; $display("FAIL wrap_pc: got pc=%h if_id_pc=%h want 0/fffffffffffffffc", bus.imem_addr, if_id_pc);
        end
        step();
        drive(1'b1, 1'b1, 1'b0, '0, 1'b1, 32'h0090_0493);
        step();
        checks++; if (bus.imem_addr !== 64'h0 || if_id_valid !== 1'b0 || if_id_instruction !== 32'h13 ||
                      if_id_pc !== 64'h0 || fetch_misaligned !== 1'b0) begin
            errors++; $display("FAIL reset_in_stall: got pc=%h valid=%b instr=%h if_id_pc=%h mis=%b want 0/0/00000013/0/0",
                               bus.imem_addr, if_id_valid, if_id_instruction, if_id_pc, fetch_misaligned);
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 32'h0);
        test_reset();
        test_sequential_fetch();
        test_stall();
        test_redirect_with_stall();
        test_misaligned();
        test_imem_wait();
        test_wrap_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
